// File: rtl/mc_control.sv
// Multicycle MIPS-style control FSM: one Moore state per microstep, with zero-gated branch and decode-time illegal flag.
// Optional macro IMM_LOGIC_EN adds andi/ori (ANDIEX/ORIEX states, zero-extended immediate).
//
// state   | meaning
// FETCH   | read instruction at PC, PC <= PC + 4
// DECODE  | register read, branch target into ALUOut, dispatch on op
// MEMADR  | load/store address = A + sext(imm)
// MEMRD   | read data memory at ALUOut
// MEMWB   | write loaded data to rt
// MEMWR   | write B to data memory at ALUOut
// EXECUTE | R-type ALU operation on A, B
// ALUWB   | write ALUOut to rd
// BEQEX   | compare A - B, take branch when zero
// ADDIEX  | A + sext(imm)
// IMMWB   | write ALUOut to rt
// JEX     | PC <= jump target
// ORIEX   | A | zext(imm)            (IMM_LOGIC_EN only)
// ANDIEX  | A & zext(imm)            (IMM_LOGIC_EN only)
module mc_control (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       imm_zext,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] EXECUTE = 4'd6;
  localparam logic [3:0] ALUWB   = 4'd7;
  localparam logic [3:0] BEQEX   = 4'd8;
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] IMMWB   = 4'd10;
  localparam logic [3:0] JEX     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

`ifdef IMM_LOGIC_EN
  localparam logic [3:0] ORIEX   = 4'd12;
  localparam logic [3:0] ANDIEX  = 4'd13;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
`endif

  logic [3:0] state_nxt;
  logic [3:0] decode_nxt;
  logic       op_ok;
  logic       funct_ok;
  logic [2:0] funct_alu;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_nxt;
  end

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_AND;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    op_ok      = 1'b1;
    decode_nxt = FETCH;
    case (op)
      OP_LW, OP_SW: decode_nxt = MEMADR;
      OP_RTYPE:     if (funct_ok) decode_nxt = EXECUTE; else op_ok = 1'b0;
      OP_BEQ:       decode_nxt = BEQEX;
      OP_ADDI:      decode_nxt = ADDIEX;
      OP_J:         decode_nxt = JEX;
`ifdef IMM_LOGIC_EN
      OP_ANDI:      decode_nxt = ANDIEX;
      OP_ORI:       decode_nxt = ORIEX;
`endif
      default:      op_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt   = FETCH;
    alu_control = ALU_AND;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    pc_en       = 1'b0;
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    imm_zext    = 1'b0;
    illegal     = 1'b0;
    case (state)
      FETCH: begin
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        ir_write    = 1'b1;
        pc_en       = 1'b1;
        state_nxt   = DECODE;
      end
      DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
        illegal     = ~op_ok;
        state_nxt   = decode_nxt;
      end
      MEMADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        state_nxt   = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord      = 1'b1;
        state_nxt = MEMWB;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu;
        state_nxt   = ALUWB;
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BEQEX: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_en       = zero;
      end
      ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        state_nxt   = IMMWB;
      end
      IMMWB: reg_write = 1'b1;
      JEX: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
`ifdef IMM_LOGIC_EN
      ORIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_OR;
        imm_zext    = 1'b1;
        state_nxt   = IMMWB;
      end
      ANDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_AND;
        imm_zext    = 1'b1;
        state_nxt   = IMMWB;
      end
`endif
      default: illegal = 1'b1;
    endcase
    // Side effects are suppressed in the cycle reset is applied so an aborted instruction leaves no trace.
    if (!reset_n) begin
      pc_en     = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk in 1 (all state updates on rising edge).
REQ-002 reset_n in 1: synchronous active-low reset, sampled on the clk rising edge.
REQ-003 op in 6: opcode field of the instruction register.
REQ-004 funct in 6: function field of the instruction register.
REQ-005 zero in 1: ALU zero flag, used combinationally.
REQ-006 alu_control out 3: ALU operation select (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT).
REQ-007 alu_src_a out 1: 0 = PC, 1 = register A.
REQ-008 alu_src_b out 2: 00 = reg B, 01 = constant 4, 10 = sign/zero-extended immediate, 11 = immediate shifted left by 2.
REQ-009 pc_src out 2: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
REQ-010 pc_en out 1: PC write enable.
REQ-011 iord out 1: memory address select, 0 = PC, 1 = ALUOut.
REQ-012 mem_write, ir_write, reg_write out 1 each: memory, IR and register-file write enables.
REQ-013 reg_dst out 1: destination select, 0 = rt, 1 = rd.
REQ-014 mem_to_reg out 1: writeback select, 0 = ALUOut, 1 = memory data.
REQ-015 imm_zext out 1: 1 = zero-extend the immediate, 0 = sign-extend.
REQ-016 illegal out 1: one-cycle pulse flagging an unsupported instruction.
REQ-017 state out 4: current FSM state encoding, for debug.

Function
REQ-018 Moore FSM with these encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BEQEX 8, ADDIEX 9, IMMWB 10, JEX 11, ORIEX 12, ANDIEX 13.
REQ-019 FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_control=010, pc_src=00, ir_write=1, pc_en=1; next state DECODE.
REQ-020 DECODE: alu_src_a=0, alu_src_b=11, alu_control=010. Next state by op: lw 100011 or sw 101011 -> MEMADR; R-type 000000 -> EXECUTE; beq 000100 -> BEQEX; addi 001000 -> ADDIEX; j 000010 -> JEX.
REQ-021 MEMADR: alu_src_a=1, alu_src_b=10, alu_control=010; next state MEMRD if op=lw, otherwise MEMWR.
REQ-022 MEMRD: iord=1; next state MEMWB. MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1; next state FETCH.
REQ-023 MEMWR: iord=1, mem_write=1; next state FETCH.
REQ-024 EXECUTE: alu_src_a=1, alu_src_b=00; alu_control from funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111; next state ALUWB.
REQ-025 ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1; next state FETCH.
REQ-026 BEQEX: alu_src_a=1, alu_src_b=00, alu_control=110, pc_src=01, pc_en=zero (combinational, same cycle); next state FETCH.
REQ-027 ADDIEX: alu_src_a=1, alu_src_b=10, alu_control=010, imm_zext=0; next state IMMWB. IMMWB: reg_dst=0, mem_to_reg=0, reg_write=1; next state FETCH.
REQ-028 JEX: pc_src=10, pc_en=1; next state FETCH.
REQ-029 Any output not listed for a state SHALL be 0 in that state.
REQ-030 Unsupported op, or R-type with an unlisted funct, decoded in DECODE: illegal=1 for that DECODE cycle only; next state FETCH; no register or memory write occurs.
REQ-031 Instruction latency: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.
REQ-032 Encodings 14-15 are unreachable; if entered, next state SHALL be FETCH with illegal=1.

Reset
REQ-033 reset_n=0 at a clk edge SHALL force state to FETCH, including mid-instruction; no partial writeback completes.
REQ-034 While reset_n=0, pc_en, ir_write, mem_write and reg_write SHALL be 0 and illegal SHALL be 0.
REQ-035 The first cycle after reset is released SHALL be a normal FETCH.

Configuration
REQ-036 The macro IMM_LOGIC_EN SHALL compile logical-immediate support in or out.
REQ-037 IMM_LOGIC_EN defined: andi 001100 -> ANDIEX (alu_control=000) and ori 001101 -> ORIEX (alu_control=001), both with alu_src_a=1, alu_src_b=10, imm_zext=1, followed by IMMWB.
REQ-038 IMM_LOGIC_EN undefined: ANDIEX and ORIEX do not exist, and opcodes 001100 and 001101 are illegal per REQ-030.

Verification
REQ-039 reset_n=0 for 2 cycles, then released with op=100011 -> states 0,1,2,3,4,0; reg_write=1 only in state 4; mem_to_reg=1.
REQ-040 op=000000, funct=101010 -> EXECUTE with alu_control=111; ALUWB with reg_dst=1 and reg_write=1.
REQ-041 op=000100 with zero=1 -> pc_en=1 in BEQEX; repeat with zero=0 -> pc_en=0.
REQ-042 op=111111 -> illegal pulses for 1 cycle in DECODE; next state FETCH; no write enables asserted.
REQ-043 reset_n=0 asserted in MEMWR during sw -> mem_write=0 on that cycle; state=0 on the next cycle.
REQ-044 op=001101 -> with IMM_LOGIC_EN: states 1,12,10 with imm_zext=1 and alu_control=001; without IMM_LOGIC_EN: illegal=1, then FETCH.
